// File: rtl/controlador_interrupcao.sv
// Interrupt controller: periodic timer plus edge-triggered external sources,
// with mask, fixed priority, cause register and saved return address.
module controlador_interrupcao #(
  parameter int NUM_FONTES  = 2,
  parameter int PC_WIDTH    = 11,
  parameter int TIMER_WIDTH = 16,
  parameter int CAUSA_WIDTH = 32,
  parameter int VETOR       = 0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_FONTES-1:0]  Fontes,
  input  logic                   SetTimer,
  input  logic [TIMER_WIDTH-1:0] TempoQuantum,
  input  logic                   EscreveMascara,
  input  logic [NUM_FONTES:0]    MascaraIn,
  input  logic [PC_WIDTH-1:0]    PCAtual,
  input  logic                   Reconhece,
  input  logic                   Retorno,
  output logic                   Desvio,
  output logic [PC_WIDTH-1:0]    EnderecoDesvio,
  output logic [CAUSA_WIDTH-1:0] Causa,
  output logic [PC_WIDTH-1:0]    PCSalvo,
  output logic                   EmServico,
  output logic [NUM_FONTES:0]    Pendentes
);

  localparam int N  = NUM_FONTES + 1;
  localparam int IW = $clog2(N + 1);

  logic [N-1:0]           mascara;
  logic [NUM_FONTES-1:0]  fontesAnt;
  logic [TIMER_WIDTH-1:0] periodo;
  logic [TIMER_WIDTH-1:0] contador;

  logic [N-1:0]  elegiveis;
  logic [N-1:0]  vencedor;
  logic [N-1:0]  novos;
  logic [IW-1:0] codigo;
  logic          rodando;
  logic          tick;

  assign rodando   = (periodo != '0);
  assign tick      = rodando && !SetTimer &&
                     (contador == TIMER_WIDTH'(1));
  assign novos     = {Fontes & ~fontesAnt, tick};
  assign elegiveis = Pendentes & mascara;
  assign Desvio    = ~EmServico & (|elegiveis);
  assign EnderecoDesvio = PC_WIDTH'(VETOR);

  // Ascending scan: the last hit is the highest index, which wins.
  always_comb begin
    vencedor = '0;
    codigo   = '0;
    for (int i = 0; i < N; i++) begin
      if (elegiveis[i]) begin
        vencedor    = '0;
        vencedor[i] = 1'b1;
        codigo      = IW'(i + 1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mascara   <= '1;
      fontesAnt <= '0;
      periodo   <= '0;
      contador  <= '0;
      Pendentes <= '0;
      Causa     <= '0;
      PCSalvo   <= '0;
      EmServico <= 1'b0;
    end else begin
      fontesAnt <= Fontes;

      if (SetTimer) begin
        periodo  <= TempoQuantum;
        contador <= TempoQuantum;
      end else if (rodando) begin
        if (contador == TIMER_WIDTH'(1))
          contador <= periodo;
        else
          contador <= contador - TIMER_WIDTH'(1);
      end

      if (EscreveMascara)
        mascara <= MascaraIn;

      // A new event on the bit being dispatched keeps it pending.
      Pendentes <= (Pendentes & ~(Desvio ? vencedor : '0)) | novos;

      if (Desvio) begin
        EmServico <= 1'b1;
        PCSalvo   <= PCAtual;
        Causa     <= CAUSA_WIDTH'(codigo);
      end else begin
        if (Retorno)
          EmServico <= 1'b0;
        if (Reconhece)
          Causa <= '0;
      end
    end
  end

endmodule

// File: tb/tb_controlador_interrupcao.sv
// Bench for controlador_interrupcao: vector table with scoreboard,
// plus hand-driven reset sequences.
module tb_controlador_interrupcao;

  logic        Clock;
  logic        Reset;
  logic [1:0]  Fontes;
  logic        SetTimer;
  logic [15:0] TempoQuantum;
  logic        EscreveMascara;
  logic [2:0]  MascaraIn;
  logic [10:0] PCAtual;
  logic        Reconhece;
  logic        Retorno;
  logic        Desvio;
  logic [10:0] EnderecoDesvio;
  logic [31:0] Causa;
  logic [10:0] PCSalvo;
  logic        EmServico;
  logic [2:0]  Pendentes;

  controlador_interrupcao dut (
    .Clock(Clock),
    .Reset(Reset),
    .Fontes(Fontes),
    .SetTimer(SetTimer),
    .TempoQuantum(TempoQuantum),
    .EscreveMascara(EscreveMascara),
    .MascaraIn(MascaraIn),
    .PCAtual(PCAtual),
    .Reconhece(Reconhece),
    .Retorno(Retorno),
    .Desvio(Desvio),
    .EnderecoDesvio(EnderecoDesvio),
    .Causa(Causa),
    .PCSalvo(PCSalvo),
    .EmServico(EmServico),
    .Pendentes(Pendentes)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [1:0]  f;
    logic        st;
    logic [15:0] tq;
    logic        em;
    logic [2:0]  mi;
    logic [10:0] pc;
    logic        rc;
    logic        rt;
    logic        d;
    logic [31:0] c;
    logic [2:0]  p;
    logic        es;
    logic [10:0] ps;
  } vec_t;

  typedef struct {
    int          row;
    logic        d;
    logic [31:0] c;
    logic [2:0]  p;
    logic        es;
    logic [10:0] ps;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(
    int f, int st, int tq, int em, int mi, int pc, int rc, int rt,
    int d, int c, int p, int es, int ps);
    vec_t v;
    v.f = 2'(f); v.st = 1'(st); v.tq = 16'(tq);
    v.em = 1'(em); v.mi = 3'(mi); v.pc = 11'(pc);
    v.rc = 1'(rc); v.rt = 1'(rt);
    v.d = 1'(d); v.c = 32'(c); v.p = 3'(p);
    v.es = 1'(es); v.ps = 11'(ps);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Fontes = '0; SetTimer = 0; TempoQuantum = '0;
    EscreveMascara = 0; MascaraIn = '0;
    Reconhece = 0; Retorno = 0;
  endtask

  task automatic chk_state(input string nm, input exp_t e);
    chk($sformatf("%s.desvio", nm), 32'(Desvio), 32'(e.d));
    chk($sformatf("%s.causa", nm), Causa, e.c);
    chk($sformatf("%s.pend", nm), 32'(Pendentes), 32'(e.p));
    chk($sformatf("%s.emserv", nm), 32'(EmServico), 32'(e.es));
    chk($sformatf("%s.pcsalvo", nm), 32'(PCSalvo), 32'(e.ps));
  endtask

  initial begin
    exp_t e;
    Reset = 0;
    PCAtual = '0;
    idle_inputs();

    // timer tick after 5 cycles, dispatch, acknowledge, stop
    tbl.push_back(mk(0,1,5,0,0,37,0,0, 0,0,0,0,0));
    repeat (4) tbl.push_back(mk(0,0,0,0,0,37,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,37,0,0, 1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,37,0,0, 0,1,0,1,37));
    tbl.push_back(mk(0,0,0,0,0,37,1,0, 0,0,0,1,37));
    tbl.push_back(mk(0,1,0,0,0,37,0,1, 0,0,0,0,37));
    // priority: both externals and timer on one edge
    tbl.push_back(mk(0,1,3,0,0,100,0,0, 0,0,0,0,37));
    tbl.push_back(mk(0,0,0,0,0,100,0,0, 0,0,0,0,37));
    tbl.push_back(mk(0,0,0,0,0,100,0,0, 0,0,0,0,37));
    tbl.push_back(mk(3,0,0,0,0,100,0,0, 1,0,7,0,37));
    tbl.push_back(mk(0,1,0,0,0,200,0,0, 0,3,3,1,200));
    tbl.push_back(mk(0,0,0,0,0,200,1,1, 1,0,3,0,200));
    tbl.push_back(mk(0,0,0,0,0,201,0,0, 0,2,1,1,201));
    tbl.push_back(mk(0,0,0,0,0,201,0,1, 1,2,1,0,201));
    tbl.push_back(mk(0,0,0,0,0,202,0,0, 0,1,0,1,202));
    tbl.push_back(mk(0,0,0,0,0,202,1,1, 0,0,0,0,202));
    // level held high dispatches once
    tbl.push_back(mk(1,0,0,0,0,300,0,0, 1,0,2,0,202));
    repeat (9) tbl.push_back(mk(1,0,0,0,0,300,0,0, 0,2,0,1,300));
    tbl.push_back(mk(0,0,0,0,0,300,1,1, 0,0,0,0,300));
    // masked pending retained, fires when unmasked
    tbl.push_back(mk(0,0,0,1,1,300,0,0, 0,0,0,0,300));
    tbl.push_back(mk(2,0,0,0,0,300,0,0, 0,0,4,0,300));
    tbl.push_back(mk(0,0,0,1,7,300,0,0, 1,0,4,0,300));
    tbl.push_back(mk(0,0,0,0,0,400,0,0, 0,3,0,1,400));
    // nesting blocked while in service
    tbl.push_back(mk(1,0,0,0,0,400,1,0, 0,0,2,1,400));
    tbl.push_back(mk(0,0,0,0,0,400,0,0, 0,0,2,1,400));
    tbl.push_back(mk(0,0,0,0,0,400,0,1, 1,0,2,0,400));
    tbl.push_back(mk(0,0,0,0,0,500,0,0, 0,2,0,1,500));
    tbl.push_back(mk(0,0,0,0,0,500,1,1, 0,0,0,0,500));
    // new edge on the bit being dispatched stays pending
    tbl.push_back(mk(1,0,0,1,5,500,0,0, 0,0,2,0,500));
    tbl.push_back(mk(0,0,0,1,7,500,0,0, 1,0,2,0,500));
    tbl.push_back(mk(1,0,0,0,0,700,0,0, 0,2,2,1,700));
    tbl.push_back(mk(0,0,0,0,0,700,1,1, 1,0,2,0,700));
    tbl.push_back(mk(0,0,0,0,0,701,0,0, 0,2,0,1,701));
    tbl.push_back(mk(0,0,0,0,0,701,1,1, 0,0,0,0,701));
    // mask write alongside dispatch uses the old mask
    tbl.push_back(mk(2,0,0,0,0,800,0,0, 1,0,4,0,701));
    tbl.push_back(mk(0,0,0,1,3,800,0,0, 0,3,0,1,800));
    tbl.push_back(mk(0,0,0,1,7,800,1,1, 0,0,0,0,800));

    // reset state
    repeat (2) @(posedge Clock);
    #1;
    e = '{row: 0, d: 0, c: 0, p: 0, es: 0, ps: 0};
    chk_state("reset", e);
    chk("reset.vetor", 32'(EnderecoDesvio), 32'd0);
    @(negedge Clock);
    Reset = 1;

    foreach (tbl[i]) begin
      @(negedge Clock);
      Fontes = tbl[i].f; SetTimer = tbl[i].st;
      TempoQuantum = tbl[i].tq; EscreveMascara = tbl[i].em;
      MascaraIn = tbl[i].mi; PCAtual = tbl[i].pc;
      Reconhece = tbl[i].rc; Retorno = tbl[i].rt;
      sb.push_back('{row: i, d: tbl[i].d, c: tbl[i].c,
                     p: tbl[i].p, es: tbl[i].es, ps: tbl[i].ps});
      @(posedge Clock);
      #1;
      if (sb.size() == 0) begin
        chk("sb.empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk_state($sformatf("row%0d", e.row), e);
      end
    end

    // reset mid-dispatch with bit 2 masked
    @(negedge Clock);
    idle_inputs();
    Fontes = 2'b01; EscreveMascara = 1; MascaraIn = 3'b010;
    @(posedge Clock);
    #1;
    chk("pre_rst.desvio", 32'(Desvio), 32'd1);
    @(negedge Clock);
    idle_inputs();
    Reset = 0;
    #1;
    e = '{row: 0, d: 0, c: 0, p: 0, es: 0, ps: 0};
    chk_state("midrst", e);
    @(negedge Clock);
    Reset = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clock);
      #1;
      chk($sformatf("quiet%0d.desvio", k), 32'(Desvio), 32'd0);
    end
    // mask must be back to all ones
    @(negedge Clock);
    Fontes = 2'b10;
    @(posedge Clock);
    #1;
    e = '{row: 0, d: 1, c: 0, p: 4, es: 0, ps: 0};
    chk_state("postrst", e);
    @(negedge Clock);
    Fontes = 2'b00; PCAtual = 11'd900;
    @(posedge Clock);
    #1;
    e = '{row: 0, d: 0, c: 3, p: 0, es: 1, ps: 900};
    chk_state("postrst_disp", e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_interrupcao.md
Name: controlador_interrupcao

Overview:
- Parametrised successor of the CPU's two-source (halt/clock) interrupt logic.
- Handles one periodic timer source plus NUM_FONTES external edge-triggered sources, with per-source mask, fixed priority, cause register and saved-PC buffer.
- Sits between the PC next-address mux and the PC; its outputs drive the PC override and the register-bank cause/PC-buffer write muxes.

Parameters:
NUM_FONTES, 2, number of external interrupt sources (bit indices 1..NUM_FONTES)
PC_WIDTH, 11, instruction address width
TIMER_WIDTH, 16, timer period/counter width
CAUSA_WIDTH, 32, width of cause code output
VETOR, 0, handler entry address driven on EnderecoDesvio

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-low reset
Fontes  input  NUM_FONTES  external requests, rising-edge sensitive
SetTimer  input  1  load timer period from TempoQuantum
TempoQuantum  input  TIMER_WIDTH  timer period; 0 stops timer
EscreveMascara  input  1  write MascaraIn into mask register
MascaraIn  input  NUM_FONTES+1  enable per source (1 = enabled)
PCAtual  input  PC_WIDTH  next PC the CPU would take this cycle
Reconhece  input  1  handler has read cause; clear Causa
Retorno  input  1  return from interrupt; leave service state
Desvio  output  1  combinational: override PC with EnderecoDesvio this cycle
EnderecoDesvio  output  PC_WIDTH  constant VETOR
Causa  output  CAUSA_WIDTH  registered cause code, 0 = none
PCSalvo  output  PC_WIDTH  registered interrupted return address
EmServico  output  1  registered: handler active, further dispatch blocked
Pendentes  output  NUM_FONTES+1  registered pending bits (bit 0 = timer)

Behaviour:
- Reset low (async):
  - Pendentes=0, Causa=0, PCSalvo=0, EmServico=0.
  - Mask=all ones; timer stopped with counter=0 and period=0.
  - Edge-detect history=0.
  - Desvio=0 follows from the cleared state.
- Edge detect:
  - Fontes registered each edge.
  - Pendentes[i] set at the edge where Fontes[i-1]=1 and the previous sample was 0.
  - A held-high level sets the bit once only.
- Timer:
  - SetTimer: period<=TempoQuantum, counter<=TempoQuantum. Running iff period!=0.
  - While running, counter decrements each edge.
  - At an edge with counter==1: counter<=period and Pendentes[0] set, giving a periodic tick every `period` cycles.
  - SetTimer has priority over decrement in the same cycle.
  - Timer keeps running during EmServico; extra ticks coalesce into one pending bit.
- Selection:
  - Eligible = Pendentes & Mask.
  - Highest index wins (external sources outrank the timer; topmost external is highest).
  - Cause code = index+1.
- Dispatch:
  - Desvio = ~EmServico & |Eligible, combinational, same cycle.
  - At the edge with Desvio=1: EmServico<=1, PCSalvo<=PCAtual, Causa<=code, the winning pending bit is cleared.
  - Latency: event at edge k -> Desvio high in cycle k..k+1 -> taken at edge k+1.
- Reconhece: Causa<=0 at the edge. Does not affect EmServico or Pendentes.
- Retorno:
  - If EmServico: EmServico<=0 at the edge. Desvio may reassert the following cycle if anything is eligible.
  - Ignored when EmServico=0.
  - PCSalvo holds its value until the next dispatch.
- Simultaneous events:
  - New event on a bit being cleared by dispatch: set wins (bit stays pending).
  - EscreveMascara with dispatch: dispatch uses the old mask.
  - Reconhece and Retorno together: both take effect.
  - Masked pending bits are retained and fire when unmasked.
- Widths: Causa is zero-extended to CAUSA_WIDTH. PCSalvo and EnderecoDesvio are exactly PC_WIDTH.

Test Plan:
- Reset: Reset low mid-dispatch -> all outputs 0, mask=all ones. Release, no stimulus 20 cycles -> Desvio stays 0.
- Timer: SetTimer with TempoQuantum=5, PCAtual=37 -> Desvio high 5 cycles after load; next edge Causa=1, PCSalvo=37, EmServico=1. Reconhece -> Causa=0.
- Priority: Fontes=2'b11 and timer tick in the same edge (NUM_FONTES=2) -> Causa=3. After Retorno -> Causa=2. After the next Retorno -> Causa=1. Each dispatch takes exactly one cycle after Retorno.
- Edge rule: Fontes[0] held high 10 cycles -> exactly one dispatch with Causa=2.
- Mask: mask=3'b001, pulse Fontes[1] -> Pendentes[2]=1, Desvio=0. Write mask=3'b111 -> Desvio next cycle, Causa=3.
- Nesting block: while EmServico=1, pulse Fontes[0] -> Desvio=0, Pendentes[1]=1. Retorno -> Desvio the next cycle, PCSalvo updated to the new PCAtual.
